regfile_write_checker: RTL and testbench
========================================

REGFILE_WRITE_CHECKER -- requirements
Module: regfile_write_checker

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data width.
REQ-002 SHALL have parameter ADDR_W, default 5: register index width.
REQ-003 SHALL have parameter DEPTH, default 8, power of two >= 2: expectation queue entries.
REQ-004 SHALL have parameter TIMEOUT, default 64, >= 1: max cycles the queue head may wait for a write.
REQ-005 SHALL have parameter STRICT, default 1: 1 flags writes with an empty queue as errors; 0 ignores them.
REQ-006 SHALL have parameter IGNORE_R0, default 1: 1 discards observed writes to register 0.
REQ-007 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-009 SHALL have port enable  in  1  checker armed.
REQ-010 SHALL have ports exp_valid in 1, exp_ready out 1, exp_reg in ADDR_W, exp_data in DATA_W: expected-write push channel.
REQ-011 SHALL have ports mon_reg_write in 1, mon_write_reg in ADDR_W, mon_write_data in DATA_W: monitored register-file write port.
REQ-012 SHALL have ports pass_cnt out 16, err_cnt out 16, err out 1 (sticky), err_code out 3, pending out $clog2(DEPTH)+1, idle out 1.

Function
REQ-013 SHALL push one entry per cycle when exp_valid and exp_ready are both high; exp_ready = !full, independent of exp_valid.
REQ-014 SHALL treat an observed write as valid only when enable and mon_reg_write are high, and not (IGNORE_R0 and mon_write_reg == 0).
REQ-015 SHALL compare a valid write against the queue head only; an entry pushed in cycle N is comparable from cycle N+1.
REQ-016 SHALL pop the head on every valid write while the queue is non-empty, regardless of match.
REQ-017 SHALL classify each comparison: reg and data equal -> pass; reg differs -> err_code 1; reg equal, data differs -> err_code 2.
REQ-018 SHALL, when STRICT=1 and the queue is empty, flag a valid write as err_code 3; pops nothing.
REQ-019 SHALL run a head-wait timer while enable and the queue is non-empty; on reaching TIMEOUT with no valid write, it SHALL pop the head and flag err_code 4.
REQ-020 SHALL reset the timer to 0 on any pop, or when the queue empties or enable drops.
REQ-021 SHALL register all comparison results: pass_cnt, err_cnt, err and err_code update exactly one cycle after the triggering write or timeout.
REQ-022 SHALL saturate pass_cnt and err_cnt at 16'hFFFF.
REQ-023 SHALL set err on the first error and hold it until reset; err_code SHALL hold the first error's code and never be overwritten.
REQ-024 SHALL allow a push and a pop in the same cycle; pending is then unchanged, and a full queue remains full.
REQ-025 SHALL drive pending as the current entry count, 0..DEPTH.
REQ-026 SHALL implement FSM states IDLE (enable low), WAIT (enabled, queue empty) and CHECK (enabled, queue non-empty).
REQ-027 SHALL use the following FSM transitions: IDLE->WAIT/CHECK on enable; WAIT<->CHECK on pending; any state->IDLE on enable low.
REQ-028 SHALL keep the queue contents and counters while in IDLE.
REQ-029 SHALL drive idle high iff the state is IDLE or WAIT.

Reset
REQ-030 SHALL, while rst is low at a clock edge, clear the queue and timer, set the state to IDLE, and drive the outputs as follows: pass_cnt=0, err_cnt=0, err=0, err_code=0, pending=0, idle=1, exp_ready=1.
REQ-031 SHALL, on reset mid-CHECK, discard all in-flight expectations and register no error for them.

Structure
REQ-032 SHALL place the err_code constants (NONE=0, BAD_REG=1, BAD_DATA=2, UNEXPECTED=3, TIMEOUT=4) and the FSM state encodings in shared package cpu_check_pkg.
REQ-033 SHALL implement the expectation queue as sub-module sync_fifo, parametrised by width ADDR_W+DATA_W and by DEPTH.

Verification
REQ-034 SHALL cover: push (reg 3, data 6); then write r3=6 -> next cycle pass_cnt=1, err=0, pending=0.
REQ-035 SHALL cover: push (reg 3, data 6); then write r3=7 -> err=1, err_code=2, err_cnt=1, pending=0.
REQ-036 SHALL cover: push (reg 3, data 6) with no write for 64 cycles -> err_code=4 in cycle 65, pending=0.
REQ-037 SHALL cover: 9 back-to-back pushes with DEPTH=8 -> exp_ready low after the 8th and pending=8; a write of the head value plus a push in the same cycle -> pending stays 8.
REQ-038 SHALL cover: STRICT=1, empty queue, write r5=1 -> err_code=3; write r0=9 with IGNORE_R0=1 -> no counter change.
REQ-039 SHALL cover: 3 entries pending, rst low for one edge -> pending=0, counters 0, idle=1, and no err afterwards.

Source files
------------

// File: rtl/cpu_check_pkg.sv
// rtl/cpu_check_pkg.sv - shared error codes, FSM states and helpers for the register-file write checker
package cpu_check_pkg;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_BAD_REG    = 3'd1,
        ERR_BAD_DATA   = 3'd2,
        ERR_UNEXPECTED = 3'd3,
        ERR_TIMEOUT    = 3'd4
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    localparam int CNT_W = 16;

    // Saturating increment used by the pass and error counters
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO holding expected register writes
module sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // A full FIFO still takes a push in the cycle it releases its head
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_FULL) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/regfile_write_checker.sv
// rtl/regfile_write_checker.sv - compares observed register-file writes against a queue of expected writes
module regfile_write_checker
    import cpu_check_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 64,
    parameter int STRICT    = 1,
    parameter int IGNORE_R0 = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [ADDR_W-1:0]        exp_reg,
    input  logic [DATA_W-1:0]        exp_data,
    input  logic                     mon_reg_write,
    input  logic [ADDR_W-1:0]        mon_write_reg,
    input  logic [DATA_W-1:0]        mon_write_data,
    output logic [15:0]              pass_cnt,
    output logic [15:0]              err_cnt,
    output logic                     err,
    output logic [2:0]               err_code,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     idle
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [PW-1:0] CNT_ONE  = PW'(1);

    logic [ADDR_W+DATA_W-1:0] fifo_rdata;
    logic                     fifo_full, fifo_empty;
    logic [PW-1:0]            fifo_count;
    logic [ADDR_W-1:0]        head_reg;
    logic [DATA_W-1:0]        head_data;

    logic      wr_valid, r0_hit;
    logic      cmp_fire, unexp_fire, tmo_fire;
    logic      push, pop, will_empty;
    logic      result_pass;
    err_code_e result_code;

    logic [TW-1:0]      timer_q, timer_d;
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_q, err_d;
    err_code_e          err_code_q, err_code_d;

    sync_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_exp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({exp_reg, exp_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_reg  = fifo_rdata[DATA_W +: ADDR_W];
    assign head_data = fifo_rdata[DATA_W-1:0];

    // Qualify the observed write, pick this cycle's event and classify it
    always_comb begin
        r0_hit      = (IGNORE_R0 != 0) && (mon_write_reg == '0);
        wr_valid    = enable && mon_reg_write && !r0_hit;
        cmp_fire    = wr_valid && !fifo_empty;
        unexp_fire  = wr_valid && fifo_empty && (STRICT != 0);
        tmo_fire    = enable && !fifo_empty && !wr_valid && (timer_q == TMO_LAST);
        pop         = cmp_fire || tmo_fire;
        push        = exp_valid && (!fifo_full || pop);
        will_empty  = (fifo_empty && !push) || ((fifo_count == CNT_ONE) && pop && !push);
        result_pass = 1'b0;
        result_code = ERR_NONE;
        if (cmp_fire) begin
            if (head_reg != mon_write_reg) begin
                result_code = ERR_BAD_REG;
            end else if (head_data != mon_write_data) begin
                result_code = ERR_BAD_DATA;
            end else begin
                result_pass = 1'b1;
            end
        end else if (unexp_fire) begin
            result_code = ERR_UNEXPECTED;
        end else if (tmo_fire) begin
            result_code = ERR_TIMEOUT;
        end
    end

    // Head-wait timer restarts whenever the head changes or checking stalls
    always_comb begin
        timer_d = timer_q + TMR_ONE;
        if (!enable || fifo_empty || pop) begin
            timer_d = '0;
        end
    end

    // Mode FSM next state: IDLE when disarmed, WAIT/CHECK follow queue occupancy
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = will_empty ? ST_WAIT : ST_CHECK;
            ST_WAIT:  if (!will_empty) state_d = ST_CHECK;
            ST_CHECK: if (will_empty) state_d = ST_WAIT;
            default:  state_d = ST_IDLE;
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
        end
    end

    // Result counters and the sticky first-error record
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        err_cnt_d  = err_cnt_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (result_pass) begin
            pass_cnt_d = sat_inc(pass_cnt_q);
        end
        if (result_code != ERR_NONE) begin
            err_cnt_d = sat_inc(err_cnt_q);
            if (!err_q) begin
                err_d      = 1'b1;
                err_code_d = result_code;
            end
        end
    end

    // Checker state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q    <= '0;
            state_q    <= ST_IDLE;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            timer_q    <= timer_d;
            state_q    <= state_d;
            pass_cnt_q <= pass_cnt_d;
            err_cnt_q  <= err_cnt_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign exp_ready = !fifo_full;
    assign pass_cnt  = pass_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign pending   = fifo_count;
    assign idle      = (state_q == ST_IDLE) || (state_q == ST_WAIT);

endmodule

// File: tb/tb_regfile_write_checker.sv
// tb/tb_regfile_write_checker.sv - self-checking bench for regfile_write_checker
module tb_regfile_write_checker;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          exp_valid;
    logic          exp_ready;
    logic [AW-1:0] exp_reg;
    logic [DW-1:0] exp_data;
    logic          mon_reg_write;
    logic [AW-1:0] mon_write_reg;
    logic [DW-1:0] mon_write_data;
    logic [15:0]   pass_cnt;
    logic [15:0]   err_cnt;
    logic          err;
    logic [2:0]    err_code;
    logic [3:0]    pending;
    logic          idle;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_write_checker #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO), .STRICT(1), .IGNORE_R0(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_reg(exp_reg), .exp_data(exp_data),
        .mon_reg_write(mon_reg_write), .mon_write_reg(mon_write_reg), .mon_write_data(mon_write_data),
        .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err(err), .err_code(err_code),
        .pending(pending), .idle(idle)
    );

    // Reference model: a queue of expectations plus scoreboard counters
    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t m_q[$];
    int   m_age;
    int   m_pass, m_errc, m_code;
    bit   m_err, m_idle;

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic void model_step(input bit r, en, ev, input logic [AW-1:0] er, input logic [DW-1:0] ed,
                                       input bit mw, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        int   sz;
        bit   popped, passed, vw;
        int   code;
        ent_t h;
        if (!r) begin
            m_q.delete();
            m_age = 0; m_pass = 0; m_errc = 0; m_code = 0; m_err = 0; m_idle = 1;
            return;
        end
        sz = m_q.size();
        vw = en && mw && (mr != 0);
        popped = 0; passed = 0; code = 0;
        if (vw && sz > 0) begin
            h = m_q.pop_front();
            popped = 1;
            if (h.r != mr) code = 1;
            else if (h.d != md) code = 2;
            else passed = 1;
        end else if (vw) begin
            code = 3;
        end else if (en && sz > 0 && m_age == TMO - 1) begin
            void'(m_q.pop_front());
            popped = 1;
            code = 4;
        end
        if (ev && (sz < DEPTH || popped)) begin
            h.r = er; h.d = ed;
            m_q.push_back(h);
        end
        m_age = (!en || popped || sz == 0) ? 0 : m_age + 1;
        if (passed) m_pass = sat(m_pass);
        if (code != 0) begin
            m_errc = sat(m_errc);
            if (!m_err) begin
                m_err = 1; m_code = code;
            end
        end
        m_idle = !en || (m_q.size() == 0);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int p, input int ec, input int e, input int c,
                             input int pd, input int rdy, input int idl);
        chk({tag, ".pass_cnt"}, int'(pass_cnt), p);
        chk({tag, ".err_cnt"},  int'(err_cnt), ec);
        chk({tag, ".err"},      int'(err), e);
        chk({tag, ".err_code"}, int'(err_code), c);
        chk({tag, ".pending"},  int'(pending), pd);
        chk({tag, ".exp_ready"}, int'(exp_ready), rdy);
        chk({tag, ".idle"},     int'(idle), idl);
    endtask

    task automatic check_model(input string tag);
        check_all(tag, m_pass, m_errc, int'(m_err), m_code, m_q.size(),
                  int'(m_q.size() < DEPTH), int'(m_idle));
    endtask

    task automatic apply(input bit r, en, ev, input logic [AW-1:0] er, input logic [DW-1:0] ed,
                         input bit mw, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        rst = r; enable = en; exp_valid = ev; exp_reg = er; exp_data = ed;
        mon_reg_write = mw; mon_write_reg = mr; mon_write_data = md;
        model_step(r, en, ev, er, ed, mw, mr, md);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit            r, en, ev;
        logic [AW-1:0] er;
        logic [DW-1:0] ed;
        bit            mw;
        logic [AW-1:0] mr;
        logic [DW-1:0] md;
        int            p, ec, e, c, pd, rdy, idl;
    } vec_t;

    function automatic vec_t mk(input bit r, en, ev, input int er, ed, input bit mw, input int mr, md,
                                input int p, ec, e, c, pd, rdy, idl);
        vec_t v;
        v.r = r; v.en = en; v.ev = ev; v.er = AW'(er); v.ed = DW'(ed);
        v.mw = mw; v.mr = AW'(mr); v.md = DW'(md);
        v.p = p; v.ec = ec; v.e = e; v.c = c; v.pd = pd; v.rdy = rdy; v.idl = idl;
        return v;
    endfunction

    vec_t vt[22];

    initial begin
        bit r, en, ev, mw;
        logic [AW-1:0] er, mr;
        logic [DW-1:0] ed, md;
        int mode;

        rst = 0; enable = 0; exp_valid = 0; exp_reg = '0; exp_data = '0;
        mon_reg_write = 0; mon_write_reg = '0; mon_write_data = '0;
        model_step(0, 0, 0, '0, '0, 0, '0, '0);

        //           r en ev er ed mw mr md   pass errc err code pend rdy idle
        vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);
        vt[1]  = mk(1, 1, 1, 3, 6, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0);
        vt[2]  = mk(1, 1, 0, 0, 0, 1, 3, 6,   1, 0, 0, 0, 0, 1, 1);
        vt[3]  = mk(1, 1, 1, 3, 6, 0, 0, 0,   1, 0, 0, 0, 1, 1, 0);
        vt[4]  = mk(1, 1, 0, 0, 0, 1, 3, 7,   1, 1, 1, 2, 0, 1, 1);
        vt[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);
        vt[6]  = mk(1, 1, 0, 0, 0, 1, 5, 1,   0, 1, 1, 3, 0, 1, 1);
        vt[7]  = mk(1, 1, 0, 0, 0, 1, 0, 9,   0, 1, 1, 3, 0, 1, 1);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);
        vt[9]  = mk(1, 1, 1, 3, 6, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0);
        vt[10] = mk(1, 1, 0, 0, 0, 1, 4, 6,   0, 1, 1, 1, 0, 1, 1);
        vt[11] = mk(1, 1, 1, 2, 5, 1, 2, 5,   0, 2, 1, 1, 1, 1, 0);
        vt[12] = mk(1, 1, 0, 0, 0, 1, 2, 5,   1, 2, 1, 1, 0, 1, 1);
        vt[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);
        vt[14] = mk(1, 1, 1, 1, 1, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0);
        vt[15] = mk(1, 1, 1, 2, 2, 0, 0, 0,   0, 0, 0, 0, 2, 1, 0);
        vt[16] = mk(1, 1, 1, 3, 3, 0, 0, 0,   0, 0, 0, 0, 3, 1, 0);
        vt[17] = mk(0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);
        vt[18] = mk(1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);
        vt[19] = mk(1, 1, 1, 7, 7, 0, 0, 0,   0, 0, 0, 0, 1, 1, 0);
        vt[20] = mk(1, 0, 0, 0, 0, 1, 7, 7,   0, 0, 0, 0, 1, 1, 1);
        vt[21] = mk(1, 1, 0, 0, 0, 1, 7, 7,   1, 0, 0, 0, 0, 1, 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < 22; i++) begin
            apply(vt[i].r, vt[i].en, vt[i].ev, vt[i].er, vt[i].ed, vt[i].mw, vt[i].mr, vt[i].md);
            check_all($sformatf("vec%0d", i), vt[i].p, vt[i].ec, vt[i].e, vt[i].c, vt[i].pd, vt[i].rdy, vt[i].idl);
        end

        // No errors appear for expectations discarded by the reset in vt[17]
        for (int i = 0; i < 70; i++) apply(1, 1, 0, '0, '0, 0, '0, '0);
        check_all("post_reset_quiet", 1, 0, 0, 0, 0, 1, 1);

        // Head-wait timeout: one push, then 64 cycles without a write
        apply(0, 0, 0, '0, '0, 0, '0, '0);
        apply(1, 1, 1, 5'd3, 32'd6, 0, '0, '0);
        for (int i = 0; i < TMO - 1; i++) apply(1, 1, 0, '0, '0, 0, '0, '0);
        check_all("tmo_before", 0, 0, 0, 0, 1, 1, 0);
        apply(1, 1, 0, '0, '0, 0, '0, '0);
        check_all("tmo_fire", 0, 1, 1, 4, 0, 1, 1);

        // Fill to DEPTH, overflow push is refused, then push+pop while full
        apply(0, 0, 0, '0, '0, 0, '0, '0);
        for (int i = 0; i < 9; i++) begin
            apply(1, 1, 1, AW'(i + 1), DW'(i * 10), 0, '0, '0);
            if (i == 7) check_all("fill8", 0, 0, 0, 0, 8, 0, 0);
        end
        check_all("fill9", 0, 0, 0, 0, 8, 0, 0);
        apply(1, 1, 1, 5'd10, 32'd99, 1, 5'd1, 32'd0);
        check_all("full_push_pop", 1, 0, 0, 0, 8, 0, 0);
        for (int i = 1; i < 8; i++) apply(1, 1, 0, '0, '0, 1, AW'(i + 1), DW'(i * 10));
        apply(1, 1, 0, '0, '0, 1, 5'd10, 32'd99);
        check_all("drain", 9, 0, 0, 0, 0, 1, 1);

        // Randomised traffic against the reference model
        apply(0, 0, 0, '0, '0, 0, '0, '0);
        mode = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 150 == 0) mode = $urandom_range(2);
            r  = ($urandom_range(599) != 0);
            en = ($urandom_range(11) != 0);
            ev = ($urandom_range(99) < ((mode == 2) ? 30 : 50));
            er = AW'($urandom_range(3));
            ed = DW'($urandom_range(3));
            mw = (mode == 1) ? 1'b0 : ($urandom_range(99) < ((mode == 2) ? 80 : 40));
            if (m_q.size() > 0 && $urandom_range(3) != 0) begin
                mr = m_q[0].r;
                md = m_q[0].d;
                if ($urandom_range(5) == 0) md = md ^ 32'd1;
                if ($urandom_range(9) == 0) mr = mr ^ 5'd1;
            end else begin
                mr = AW'($urandom_range(3));
                md = DW'($urandom_range(3));
            end
            apply(r, en, ev, er, ed, mw, mr, md);
            check_model($sformatf("rnd%0d", cyc));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
